// File: rtl/rx_align_pkg.sv
// ============================================================================
// rx_align_pkg : shared widths, K28.5 patterns and alignment state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package rx_align_pkg;

  localparam int SYM_W = 10;
  localparam int CNT_W = 4;

  localparam logic [SYM_W-1:0] K28_5_N = 10'b0011111010;
  localparam logic [SYM_W-1:0] K28_5_P = 10'b1100000101;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_comma_detect.sv
// ============================================================================
// rx_comma_detect : flags a 10-bit window equal to either K28.5 disparity form
// Rev 1.0
// ============================================================================
`default_nettype none

module rx_comma_detect
  import rx_align_pkg::*;
#(
  parameter logic [SYM_W-1:0] COMMA_N = K28_5_N,
  parameter logic [SYM_W-1:0] COMMA_P = K28_5_P
) (
  input  logic [SYM_W-1:0] window,
  output logic             hit
);

  assign hit = (window == COMMA_N) || (window == COMMA_P);

endmodule

`default_nettype wire

// File: rtl/rx_symbol_aligner.sv
// ============================================================================
// rx_symbol_aligner : serial K28.5 hunt/verify/lock, emits aligned 10-bit words
// Optional err_cnt output enabled by RX_ALIGN_ERRCNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module rx_symbol_aligner
  import rx_align_pkg::*;
#(
  parameter logic [SYM_W-1:0] COMMA_N    = K28_5_N,
  parameter logic [SYM_W-1:0] COMMA_P    = K28_5_P,
  parameter int unsigned      VERIFY_CNT = 3,
  parameter int unsigned      LOSS_CNT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [SYM_W-1:0] data_tx,
  output logic             data_valid,
  output logic             is_comma,
  output logic             locked,
  output logic [1:0]       align_state
`ifdef RX_ALIGN_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam logic [CNT_W-1:0] VERIFY_N = CNT_W'(VERIFY_CNT);
  localparam logic [CNT_W-1:0] LOSS_N   = CNT_W'(LOSS_CNT);
  localparam logic [3:0]       LAST_BIT = 4'd9;

  align_state_e     state_q, state_d;
  // Only the newest nine bits are kept; the incoming bit completes the window.
  logic [SYM_W-2:0] sr_q, sr_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic [SYM_W-1:0] data_q, data_d;
  logic             dv_q, dv_d;
  logic             comma_q, comma_d;

  logic [SYM_W-1:0] window;
  logic             hit;
  logic             boundary;

  assign window   = {sr_q, bit_in};
  assign boundary = (bit_cnt_q == LAST_BIT);

  rx_comma_detect #(
    .COMMA_N (COMMA_N),
    .COMMA_P (COMMA_P)
  ) u_comma_detect (
    .window (window),
    .hit    (hit)
  );

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    good_d    = good_q;
    loss_d    = loss_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    comma_d   = 1'b0;

    if (bit_valid) begin
      sr_d      = window[SYM_W-2:0];
      bit_cnt_d = boundary ? 4'd0 : bit_cnt_q + 4'd1;

      case (state_q)
        HUNT: begin
          if (hit) begin
            bit_cnt_d = 4'd0;
            good_d    = CNT_W'(1);
            if (VERIFY_N == CNT_W'(1)) begin
              state_d = LOCKED;
              loss_d  = '0;
            end else begin
              state_d = VERIFY;
            end
          end
        end

        VERIFY: begin
          if (hit && boundary) begin
            good_d = sat_inc(good_q);
            if (good_d >= VERIFY_N) begin
              state_d = LOCKED;
              loss_d  = '0;
            end
          end else if (hit) begin
            state_d = HUNT;
            good_d  = '0;
          end
        end

        LOCKED: begin
          if (boundary) begin
            data_d  = window;
            dv_d    = 1'b1;
            comma_d = hit;
            if (hit) begin
              loss_d = '0;
            end
          end else if (hit) begin
            loss_d = sat_inc(loss_q);
            if (loss_d >= LOSS_N) begin
              state_d = HUNT;
              good_d  = '0;
              loss_d  = '0;
            end
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      good_q    <= '0;
      loss_q    <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      comma_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      good_q    <= good_d;
      loss_q    <= loss_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      comma_q   <= comma_d;
    end
  end

`ifdef RX_ALIGN_ERRCNT_EN
  logic [7:0] err_q, err_d;
  logic       off_hit;

  // A misaligned comma only counts once alignment has been acquired.
  assign off_hit = bit_valid && hit && !boundary && (state_q != HUNT);

  always_comb begin
    err_d = err_q;
    if (off_hit && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`endif

  assign data_tx     = data_q;
  assign data_valid  = dv_q;
  assign is_comma    = comma_q;
  assign locked      = (state_q == LOCKED);
  assign align_state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_symbol_aligner.sv
// ============================================================================
// tb_rx_symbol_aligner : randomized stimulus checked against a bit-history model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rx_symbol_aligner;

  localparam logic [9:0] KN   = 10'b0011111010;
  localparam logic [9:0] KP   = 10'b1100000101;
  localparam logic [9:0] D215 = 10'b1010101010;
  localparam int         VC   = 3;
  localparam int         LC   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic [9:0] data_tx;
  logic       data_valid;
  logic       is_comma;
  logic       locked;
  logic [1:0] align_state;
`ifdef RX_ALIGN_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  rx_symbol_aligner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .data_tx     (data_tx),
    .data_valid  (data_valid),
    .is_comma    (is_comma),
    .locked      (locked),
    .align_state (align_state)
`ifdef RX_ALIGN_ERRCNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // Reference model: last ten received bits plus the bit count at acquisition.
  bit         hist[$];
  int         nbits, anchor;
  int         m_state, m_good, m_loss, m_err;
  logic [9:0] m_data;
  bit         m_dv, m_comma;

  typedef struct {
    bit r;
    bit v;
    bit b;
  } stim_t;
  stim_t sq[$];

  function automatic bit rbit();
    logic [31:0] x;
    x = $urandom;
    return x[0];
  endfunction

  function automatic logic [9:0] last10();
    logic [9:0] w;
    w = '0;
    for (int i = 0; i < 10; i++)
      if (hist.size() > i) w[i] = hist[hist.size()-1-i];
    return w;
  endfunction

  function automatic void model_step(input bit r, input bit v, input bit b);
    logic [9:0] w;
    bit         hit, on;
    if (!r) begin
      hist.delete();
      nbits = 0; anchor = 0;
      m_state = 0; m_good = 0; m_loss = 0; m_err = 0;
      m_data = '0; m_dv = 0; m_comma = 0;
      return;
    end
    m_dv = 0;
    m_comma = 0;
    if (!v) return;
    hist.push_back(b);
    if (hist.size() > 10) void'(hist.pop_front());
    nbits++;
    w   = last10();
    hit = (w == KN) || (w == KP);
    on  = ((nbits - anchor) % 10) == 0;
    if (m_state == 0) begin
      if (hit) begin
        anchor = nbits;
        m_good = 1;
        if (m_good >= VC) begin m_state = 2; m_loss = 0; end
        else m_state = 1;
      end
    end else if (m_state == 1) begin
      if (hit && on) begin
        m_good++;
        if (m_good >= VC) begin m_state = 2; m_loss = 0; end
      end else if (hit) begin
        m_state = 0; m_good = 0;
        if (m_err < 255) m_err++;
      end
    end else begin
      if (on) begin
        m_dv = 1; m_data = w; m_comma = hit;
        if (hit) m_loss = 0;
      end else if (hit) begin
        if (m_err < 255) m_err++;
        m_loss++;
        if (m_loss >= LC) begin m_state = 0; m_good = 0; m_loss = 0; end
      end
    end
  endfunction

  function automatic logic [22:0] m_pack();
    logic [7:0] e;
    e = '0;
`ifdef RX_ALIGN_ERRCNT_EN
    e = 8'(m_err);
`endif
    return {m_dv, m_comma, (m_state == 2), 2'(m_state), m_data, e};
  endfunction

  function automatic logic [22:0] dut_pack();
    logic [7:0] e;
    e = '0;
`ifdef RX_ALIGN_ERRCNT_EN
    e = err_cnt;
`endif
    return {data_valid, data_valid & is_comma, locked, align_state, data_tx, e};
  endfunction

  function automatic void push_bit(input bit v, input bit b, input bit r = 1'b1);
    stim_t s;
    s.r = r; s.v = v; s.b = b;
    sq.push_back(s);
  endfunction

  function automatic void push_sym(input logic [9:0] s, input int gap);
    for (int i = 9; i >= 0; i--) begin
      push_bit(1'b1, s[i]);
      repeat (gap) push_bit(1'b0, rbit());
    end
  endfunction

  function automatic void push_rst(input int n);
    repeat (n) push_bit(rbit(), rbit(), 1'b0);
  endfunction

  function automatic void push_kd(input int n, input int gap);
    for (int k = 0; k < n; k++)
      push_sym((k % 4 == 0) ? KN : (k % 4 == 2) ? KP : D215, gap);
  endfunction

  // Misaligned comma: three filler bits shift the comma by 3 positions.
  function automatic void push_shifted();
    push_bit(1'b1, 1'b0);
    push_bit(1'b1, 1'b1);
    push_bit(1'b1, 1'b0);
    push_sym(KN, 0);
  endfunction

  task automatic cyc(input bit r, input bit v, input bit b);
    rst_n = r; bit_valid = v; bit_in = b;
    @(posedge clk);
    model_step(r, v, b);
    #1;
  endtask

  task automatic test_reset();
    sq.delete();
    push_rst(2);
    push_kd(6, 0);
    foreach (sq[i]) begin
      cyc(sq[i].r, sq[i].v, sq[i].b);
      vectors++;
      if (dut_pack() !== m_pack()) begin
        fails++;
        $display("FAIL reset_prelock cyc %0d: got %h want %h", i, dut_pack(), m_pack());
      end
    end
    vectors++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL reset_prelock_locked: got %b want 1", locked);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, rbit());
      vectors++;
      if ({data_valid, is_comma, locked, align_state, data_tx} !== 15'd0) begin
        fails++;
        $display("FAIL reset_hold cyc %0d: got %h want 0", i,
                 {data_valid, is_comma, locked, align_state, data_tx});
      end
    end
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      vectors++;
      if (align_state !== 2'd0 || dut_pack() !== m_pack()) begin
        fails++;
        $display("FAIL reset_release cyc %0d: got %h want %h", i, dut_pack(), m_pack());
      end
    end
  endtask

  task automatic test_clean_lock();
    int first_dv = -1;
    int first_lk = -1;
    logic [9:0] first_data = '0;
    bit first_comma = 1'b1;
    sq.delete();
    push_rst(2);
    push_kd(8, 0);
    foreach (sq[i]) begin
      cyc(sq[i].r, sq[i].v, sq[i].b);
      vectors++;
      if (dut_pack() !== m_pack()) begin
        fails++;
        $display("FAIL clean_lock cyc %0d: got %h want %h", i, dut_pack(), m_pack());
      end
      if (locked === 1'b1 && first_lk < 0) first_lk = i;
      if (data_valid === 1'b1 && first_dv < 0) begin
        first_dv = i; first_data = data_tx; first_comma = is_comma;
      end
    end
    vectors++;
    if (first_lk !== 2 + 49) begin
      fails++;
      $display("FAIL clean_lock_time: got %0d want %0d", first_lk, 2 + 49);
    end
    vectors++;
    if (first_dv !== 2 + 59 || first_data !== D215 || first_comma !== 1'b0) begin
      fails++;
      $display("FAIL clean_first_sym: got idx %0d data %b comma %b want idx %0d data %b comma 0",
               first_dv, first_data, first_comma, 2 + 59, D215);
    end
  endtask

  task automatic test_gaps();
    int last = -1;
    int nstb = 0;
    sq.delete();
    push_rst(2);
    push_kd(10, 1);
    foreach (sq[i]) begin
      cyc(sq[i].r, sq[i].v, sq[i].b);
      vectors++;
      if (dut_pack() !== m_pack()) begin
        fails++;
        $display("FAIL gaps cyc %0d: got %h want %h", i, dut_pack(), m_pack());
      end
      if (data_valid === 1'b1) begin
        if (last >= 0) begin
          vectors++;
          if (i - last !== 20) begin
            fails++;
            $display("FAIL gaps_spacing: got %0d want 20", i - last);
          end
        end
        last = i;
        nstb++;
      end
    end
    vectors++;
    if (nstb !== 5) begin
      fails++;
      $display("FAIL gaps_count: got %0d want 5", nstb);
    end
  endtask

  task automatic test_verify_slip();
    logic [1:0] want [3] = '{2'd1, 2'd0, 2'd2};
    for (int ph = 0; ph < 3; ph++) begin
      sq.delete();
      if (ph == 0) begin push_rst(2); push_sym(KN, 0); end
      if (ph == 1) begin push_bit(1'b1, 1'b0); push_sym(KP, 0); end
      if (ph == 2) begin
        push_sym(D215, 0); push_sym(KN, 0); push_sym(D215, 0);
        push_sym(KP, 0); push_sym(D215, 0); push_sym(KN, 0);
      end
      foreach (sq[i]) begin
        cyc(sq[i].r, sq[i].v, sq[i].b);
        vectors++;
        if (dut_pack() !== m_pack()) begin
          fails++;
          $display("FAIL slip ph%0d cyc %0d: got %h want %h", ph, i, dut_pack(), m_pack());
        end
      end
      vectors++;
      if (align_state !== want[ph]) begin
        fails++;
        $display("FAIL slip_state ph%0d: got %0d want %0d", ph, align_state, want[ph]);
      end
    end
  endtask

  task automatic test_loss_of_lock();
    for (int run = 0; run < 2; run++) begin
      sq.delete();
      push_rst(2);
      push_kd(6, 0);
      if (run == 0) begin
        repeat (4) push_shifted();
      end else begin
        repeat (3) push_shifted();
        push_bit(1'b1, 1'b0);
        push_sym(KN, 0);
        push_shifted();
      end
      foreach (sq[i]) begin
        cyc(sq[i].r, sq[i].v, sq[i].b);
        vectors++;
        if (dut_pack() !== m_pack()) begin
          fails++;
          $display("FAIL loss run%0d cyc %0d: got %h want %h", run, i, dut_pack(), m_pack());
        end
      end
      vectors++;
      if (locked !== (run == 1)) begin
        fails++;
        $display("FAIL loss_final run%0d: got locked %b want %b", run, locked, run == 1);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    sq.delete();
    push_rst(2);
    for (int k = 0; k < 150; k++) begin
      int gap;
      r = $urandom;
      gap = (r[9:8] == 2'd0) ? 1 : 0;
      if (r[21:16] == 6'd0) push_rst(1);
      case (r[3:0] % 10)
        0, 1, 2: push_sym(KN, gap);
        3, 4:    push_sym(KP, gap);
        5, 6, 7: push_sym(D215, gap);
        8:       push_sym(10'(r[31:22]), gap);
        default: begin
          repeat (1 + (r[13:12] % 3)) push_bit(1'b1, rbit());
          push_sym(KN, gap);
        end
      endcase
    end
    foreach (sq[i]) begin
      cyc(sq[i].r, sq[i].v, sq[i].b);
      vectors++;
      if (dut_pack() !== m_pack()) begin
        fails++;
        $display("FAIL random cyc %0d: got %h want %h", i, dut_pack(), m_pack());
      end
    end
  endtask

`ifdef RX_ALIGN_ERRCNT_EN
  task automatic test_errcnt();
    sq.delete();
    push_rst(2);
    repeat (600) push_shifted();
    foreach (sq[i]) begin
      cyc(sq[i].r, sq[i].v, sq[i].b);
      vectors++;
      if (dut_pack() !== m_pack()) begin
        fails++;
        $display("FAIL errcnt cyc %0d: got %h want %h", i, dut_pack(), m_pack());
      end
    end
    vectors++;
    if (err_cnt !== 8'd255) begin
      fails++;
      $display("FAIL errcnt_sat: got %0d want 255", err_cnt);
    end
    cyc(1'b0, 1'b1, 1'b0);
    vectors++;
    if (err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL errcnt_reset: got %0d want 0", err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_lock();
    test_gaps();
    test_verify_slip();
    test_loss_of_lock();
    test_random();
`ifdef RX_ALIGN_ERRCNT_EN
    test_errcnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
